// File: rtl/ml_pkg.sv
// Shared opcode constants and decoder state encoding for the ML command path.
package ml_pkg;

   localparam logic [7:0] ML_OP_NOP     = 8'h00;
   localparam logic [7:0] ML_OP_WRITE   = 8'h01;
   localparam logic [7:0] ML_OP_RUN     = 8'h02;
   localparam logic [7:0] ML_OP_CLR_ERR = 8'h03;

   typedef logic [2:0] ml_state_t;

   localparam ml_state_t ST_IDLE    = 3'd0;
   localparam ml_state_t ST_ADDR_HI = 3'd1;
   localparam ml_state_t ST_ADDR_LO = 3'd2;
   localparam ml_state_t ST_DATA    = 3'd3;
   localparam ml_state_t ST_DROP    = 3'd4;

   function automatic logic is_legal_op(input logic [7:0] op);
      return op <= ML_OP_CLR_ERR;
   endfunction

endpackage

// File: rtl/ml_word_fifo.sv
// Two-entry FIFO holding {address, data} words bound for memory.
module ml_word_fifo #(
   parameter int W = 48
) (
   input  logic         clock,
   input  logic         resetn,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty
);

   logic [W-1:0] mem_reg [2];
   logic         rd_ptr_reg;
   logic         wr_ptr_reg;
   logic [1:0]   count_reg;
   logic         do_push;
   logic         do_pop;

   assign full    = (count_reg == 2'd2);
   assign empty   = (count_reg == 2'd0);
   assign do_pop  = pop && !empty;
   // A full buffer still accepts a word when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign head    = mem_reg[rd_ptr_reg];

   for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clock or negedge resetn) begin
         if (!resetn)
            mem_reg[gi] <= '0;
         else if (do_push && (wr_ptr_reg == 1'(gi)))
            mem_reg[gi] <= push_data;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         rd_ptr_reg <= 1'b0;
         wr_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else begin
         if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
         if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 2'd1;
            2'b01:   count_reg <= count_reg - 2'd1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/ml_cmd_decoder.sv
// Host command decoder: opcode FSM, MSB-first word packing, error tracking and
// the memory-side word buffer.
module ml_cmd_decoder
   import ml_pkg::*;
#(
   parameter int ADDR_BITS = 16
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic                 frame,
   input  logic                 din_valid,
   input  logic [7:0]           din_data,
   output logic                 mem_valid,
   input  logic                 mem_ready,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic [31:0]          mem_wdata,
   output logic                 run_start,
   output logic                 ml_rdy,
   output logic                 ml_err
);

   ml_state_t              state_reg;
   logic [7:0]             addr_hi_reg;
   logic [ADDR_BITS-1:0]   addr_reg;
   logic [23:0]            acc_reg;
   logic [1:0]             byte_cnt_reg;
   logic                   run_reg;
   logic                   err_reg;

   logic                   byte_ev;
   logic                   push;
   logic                   pop;
   logic                   full;
   logic                   empty;
   logic                   overflow;
   logic                   frame_err;
   logic                   err_set;
   logic                   err_clr;
   logic [15:0]            addr_full;
   logic [ADDR_BITS+31:0]  head;

   assign byte_ev   = frame && din_valid;
   assign push      = byte_ev && (state_reg == ST_DATA) && (byte_cnt_reg == 2'd3);
   assign pop       = mem_valid && mem_ready;
   assign overflow  = push && full && !pop;
   assign addr_full = {addr_hi_reg, din_data};

   assign frame_err = !frame && ((state_reg == ST_ADDR_HI) || (state_reg == ST_ADDR_LO) ||
                                 ((state_reg == ST_DATA) && (byte_cnt_reg != 2'd0)));
   assign err_set   = overflow || frame_err ||
                      (byte_ev && (state_reg == ST_IDLE) && !is_legal_op(din_data));
   assign err_clr   = byte_ev && (state_reg == ST_IDLE) && (din_data == ML_OP_CLR_ERR);

   ml_word_fifo #(.W(ADDR_BITS + 32)) u_fifo (
      .clock     (clock),
      .resetn    (resetn),
      .push      (push),
      .push_data ({addr_reg, acc_reg, din_data}),
      .pop       (pop),
      .head      (head),
      .full      (full),
      .empty     (empty)
   );

   assign mem_valid = !empty;
   assign mem_addr  = head[ADDR_BITS+31:32];
   assign mem_wdata = head[31:0];
   assign ml_rdy    = !full;
   assign run_start = run_reg;
   assign ml_err    = err_reg;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_reg    <= ST_IDLE;
         addr_hi_reg  <= 8'h00;
         addr_reg     <= '0;
         acc_reg      <= 24'h0;
         byte_cnt_reg <= 2'd0;
         run_reg      <= 1'b0;
         err_reg      <= 1'b0;
      end else begin
         run_reg <= byte_ev && (state_reg == ST_IDLE) && (din_data == ML_OP_RUN);
         // Set has priority so an error in the same cycle as CLR_ERR is not lost.
         if (err_set)      err_reg <= 1'b1;
         else if (err_clr) err_reg <= 1'b0;

         if (!frame) begin
            state_reg    <= ST_IDLE;
            byte_cnt_reg <= 2'd0;
         end else if (din_valid) begin
            case (state_reg)
               ST_IDLE:    state_reg <= (din_data == ML_OP_WRITE) ? ST_ADDR_HI : ST_DROP;
               ST_ADDR_HI: begin
                  addr_hi_reg <= din_data;
                  state_reg   <= ST_ADDR_LO;
               end
               ST_ADDR_LO: begin
                  addr_reg     <= addr_full[ADDR_BITS-1:0];
                  byte_cnt_reg <= 2'd0;
                  state_reg    <= ST_DATA;
               end
               ST_DATA: begin
                  byte_cnt_reg <= byte_cnt_reg + 2'd1;
                  if (byte_cnt_reg == 2'd3)
                     addr_reg <= addr_reg + ADDR_BITS'(1);
                  else
                     acc_reg <= {acc_reg[15:0], din_data};
               end
               default:    state_reg <= ST_DROP;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ml_cmd_decoder.sv
// Self-checking bench for ml_cmd_decoder: table-driven writes plus directed corner sequences.
module tb_ml_cmd_decoder;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic        frame = 1'b0;
   logic        din_valid = 1'b0;
   logic [7:0]  din_data = 8'h00;
   logic        mem_valid;
   logic        mem_ready = 1'b0;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        run_start;
   logic        ml_rdy;
   logic        ml_err;

   typedef struct {
      logic [15:0] addr;
      logic [31:0] data;
   } vec_t;

   vec_t vecs[4];
   vec_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   run_cnt = 0;

   ml_cmd_decoder #(.ADDR_BITS(16)) dut (
      .clock     (clock),
      .resetn    (resetn),
      .frame     (frame),
      .din_valid (din_valid),
      .din_data  (din_data),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .run_start (run_start),
      .ml_rdy    (ml_rdy),
      .ml_err    (ml_err)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   // One clock cycle: observe outputs at negedge, then step to just past posedge.
   task automatic tick();
      vec_t e;
      @(negedge clock);
      if (run_start) run_cnt++;
      if (resetn && mem_valid && mem_ready) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL pop_unexpected got addr=%h data=%h want none", mem_addr, mem_wdata);
         end else begin
            e = sb.pop_front();
            if (mem_addr !== e.addr || mem_wdata !== e.data) begin
               bad++;
               $display("FAIL pop got addr=%h data=%h want addr=%h data=%h",
                        mem_addr, mem_wdata, e.addr, e.data);
            end else begin
               $display("pop ok addr=%h data=%h", mem_addr, mem_wdata);
            end
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      din_valid = 1'b1;
      din_data  = b;
      tick();
      din_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      send_byte(w[31:24]);
      send_byte(w[23:16]);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
   endtask

   task automatic expect_word(input logic [15:0] a, input logic [31:0] d);
      vec_t e;
      e.addr = a;
      e.data = d;
      sb.push_back(e);
   endtask

   task automatic frame_on();
      frame = 1'b1;
      tick();
   endtask

   task automatic frame_off();
      frame = 1'b0;
      tick();
      tick();
   endtask

   task automatic clear_err();
      frame_on();
      send_byte(8'h03);
      frame_off();
   endtask

   initial begin
      logic [31:0] d;
      vecs[0] = '{addr: 16'h0100, data: 32'h01234567};
      vecs[1] = '{addr: 16'h7FFE, data: 32'h89ABCDEF};
      vecs[2] = '{addr: 16'h00FF, data: 32'hFFFFFFFF};
      vecs[3] = '{addr: 16'hA5A5, data: 32'h00000000};

      #12;
      check("rst_mem_valid", 32'(mem_valid), 32'd0);
      check("rst_mem_addr",  32'(mem_addr),  32'd0);
      check("rst_mem_wdata", mem_wdata,      32'd0);
      check("rst_run_start", 32'(run_start), 32'd0);
      check("rst_ml_rdy",    32'(ml_rdy),    32'd1);
      check("rst_ml_err",    32'(ml_err),    32'd0);
      @(posedge clock);
      #1;
      resetn = 1'b1;
      tick();

      // Two-word write, no backpressure, with latency check around byte EF.
      mem_ready = 1'b1;
      frame_on();
      send_byte(8'h01); send_byte(8'h00); send_byte(8'h10);
      send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE);
      check("lat_before_ef", 32'(mem_valid), 32'd0);
      expect_word(16'h0010, 32'hDEADBEEF);
      send_byte(8'hEF);
      check("lat_after_ef", 32'(mem_valid), 32'd1);
      expect_word(16'h0011, 32'h11223344);
      send_word(32'h11223344);
      frame_off();
      check("wr_err", 32'(ml_err), 32'd0);
      check("wr_drained", 32'(sb.size()), 32'd0);

      // Table-driven single-word writes.
      for (int i = 0; i < 4; i++) begin
         d = vecs[i].data;
         frame_on();
         send_byte(8'h01);
         send_byte(vecs[i].addr[15:8]);
         send_byte(vecs[i].addr[7:0]);
         send_byte(d[31:24]); send_byte(d[23:16]); send_byte(d[15:8]);
         check($sformatf("vec%0d_pre", i), 32'(mem_valid), 32'd0);
         expect_word(vecs[i].addr, d);
         send_byte(d[7:0]);
         check($sformatf("vec%0d_lat", i), 32'(mem_valid), 32'd1);
         frame_off();
         check($sformatf("vec%0d_err", i), 32'(ml_err), 32'd0);
      end
      check("vec_drained", 32'(sb.size()), 32'd0);

      // Backpressure and overflow.
      mem_ready = 1'b0;
      frame_on();
      send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
      expect_word(16'h0000, 32'hA0A1A2A3);
      send_word(32'hA0A1A2A3);
      check("ovf_rdy_1", 32'(ml_rdy), 32'd1);
      expect_word(16'h0001, 32'hB0B1B2B3);
      send_word(32'hB0B1B2B3);
      check("ovf_rdy_2", 32'(ml_rdy), 32'd0);
      send_word(32'hC0C1C2C3);
      frame_off();
      check("ovf_err", 32'(ml_err), 32'd1);
      check("ovf_head_addr", 32'(mem_addr), 32'h0000);
      mem_ready = 1'b1;
      tick(); tick(); tick();
      check("ovf_rdy_after", 32'(ml_rdy), 32'd1);
      check("ovf_empty", 32'(mem_valid), 32'd0);
      check("ovf_drained", 32'(sb.size()), 32'd0);
      clear_err();
      check("ovf_clr", 32'(ml_err), 32'd0);

      // Address wrap and partial word at frame end.
      frame_on();
      send_byte(8'h01); send_byte(8'hFF); send_byte(8'hFF);
      expect_word(16'hFFFF, 32'h12345678);
      send_word(32'h12345678);
      expect_word(16'h0000, 32'h9ABCDEF0);
      send_word(32'h9ABCDEF0);
      send_byte(8'h55); send_byte(8'h66);
      check("wrap_err_pre", 32'(ml_err), 32'd0);
      frame_off();
      check("wrap_err", 32'(ml_err), 32'd1);
      check("wrap_partial", 32'(mem_valid), 32'd0);
      check("wrap_drained", 32'(sb.size()), 32'd0);
      clear_err();
      check("wrap_clr", 32'(ml_err), 32'd0);

      // Illegal opcode, then clear.
      frame_on();
      send_byte(8'h7E); send_byte(8'hAA);
      frame_off();
      check("ill_err", 32'(ml_err), 32'd1);
      check("ill_nowrite", 32'(mem_valid), 32'd0);
      clear_err();
      check("ill_clr", 32'(ml_err), 32'd0);

      // Run strobe followed by a write opcode that must be dropped.
      run_cnt = 0;
      frame_on();
      send_byte(8'h02);
      check("run_pulse", 32'(run_start), 32'd1);
      tick();
      check("run_one", 32'(run_start), 32'd0);
      send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
      send_word(32'hDEADBEEF);
      frame_off();
      check("run_count", 32'(run_cnt), 32'd1);
      check("run_nowrite", 32'(mem_valid), 32'd0);
      check("run_err", 32'(ml_err), 32'd0);

      // Bytes with frame low must not move the FSM; a following RUN still decodes.
      run_cnt = 0;
      send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
      frame_on();
      send_byte(8'h02);
      tick();
      frame_off();
      check("nofr_run", 32'(run_cnt), 32'd1);
      check("nofr_err", 32'(ml_err), 32'd0);

      // Asynchronous reset mid-DATA with one word buffered and the error flag set.
      frame_on();
      send_byte(8'h7E);
      frame_off();
      mem_ready = 1'b0;
      frame_on();
      send_byte(8'h01); send_byte(8'h00); send_byte(8'h40);
      send_word(32'hCAFEF00D);
      send_byte(8'h11); send_byte(8'h22);
      check("ar_pre_valid", 32'(mem_valid), 32'd1);
      check("ar_pre_err", 32'(ml_err), 32'd1);
      #2;
      resetn = 1'b0;
      #1;
      check("ar_valid", 32'(mem_valid), 32'd0);
      check("ar_rdy", 32'(ml_rdy), 32'd1);
      check("ar_err", 32'(ml_err), 32'd0);
      frame = 1'b0;
      @(posedge clock);
      #1;
      resetn = 1'b1;
      mem_ready = 1'b1;
      tick();
      frame_on();
      send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
      expect_word(16'h0005, 32'h0BADC0DE);
      send_word(32'h0BADC0DE);
      frame_off();
      check("ar_after_drained", 32'(sb.size()), 32'd0);
      check("ar_after_err", 32'(ml_err), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
